// File: rtl/fir_feeder.sv
`default_nettype none
// ============================================================================
// Module   : fir_feeder
// Purpose  : Front end for a small FIR filter. Holds the coefficient bank,
//            buffers incoming samples in a FIFO, and paces them onto the filter
//            input with an active-low advance enable. A flush request injects
//            FLUSH_LEN zero samples so the filter pipeline drains cleanly.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   iClk_12M      in   clock, all logic on its rising edge
//   iRst          in   synchronous active-high reset
//   iCoefWr       in   coefficient write strobe (IDLE only)
//   iCoefAddr     in   coefficient index 0..NTAP-1
//   iCoefData     in   signed 16-bit coefficient value
//   iSampleValid  in   upstream sample valid
//   iSample       in   signed 3-bit sample
//   oSampleReady  out  sample accepted when valid and ready are both 1
//   iStall        in   downstream pause request
//   iFlush        in   single-cycle flush request (acted on in RUN)
//   oCoeff1..10   out  coefficient registers, index k drives oCoeff(k+1)
//   oFirIn        out  registered sample to the filter
//   oEnAcc        out  active-low filter advance enable (registered)
//   oBusy         out  1 whenever the controller is not IDLE
//   oCoefErr      out  sticky flag for rejected coefficient writes
// ============================================================================
module fir_feeder #(
   parameter int NTAP      = 10,
   parameter int FDEPTH    = 4,
   parameter int FLUSH_LEN = 11
) (
   input  logic               iClk_12M,
   input  logic               iRst,
   input  logic               iCoefWr,
   input  logic        [3:0]  iCoefAddr,
   input  logic signed [15:0] iCoefData,
   input  logic               iSampleValid,
   input  logic signed [2:0]  iSample,
   output logic               oSampleReady,
   input  logic               iStall,
   input  logic               iFlush,
   output logic signed [15:0] oCoeff1,
   output logic signed [15:0] oCoeff2,
   output logic signed [15:0] oCoeff3,
   output logic signed [15:0] oCoeff4,
   output logic signed [15:0] oCoeff5,
   output logic signed [15:0] oCoeff6,
   output logic signed [15:0] oCoeff7,
   output logic signed [15:0] oCoeff8,
   output logic signed [15:0] oCoeff9,
   output logic signed [15:0] oCoeff10,
   output logic signed [2:0]  oFirIn,
   output logic               oEnAcc,
   output logic               oBusy,
   output logic               oCoefErr
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int c_AW     = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
   localparam int c_FCW    = $clog2(FLUSH_LEN + 1);
   localparam int c_NOUT   = 10;

   localparam logic [c_AW:0]    c_FULL_CNT  = (c_AW + 1)'(FDEPTH);
   localparam logic [c_AW:0]    c_CNT_ONE   = (c_AW + 1)'(1);
   localparam logic [c_AW-1:0]  c_PTR_ONE   = c_AW'(1);
   localparam logic [c_FCW-1:0] c_FLUSH_LEN = c_FCW'(FLUSH_LEN);
   localparam logic [c_FCW-1:0] c_FCNT_ONE  = c_FCW'(1);
   localparam logic [4:0]       c_NTAP      = 5'(NTAP);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_FLUSH = 2'd2;

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   logic [1:0]         state_q,      state_d;
   logic               flush_pend_q, flush_pend_d;
   logic [c_FCW-1:0]   fcnt_q,       fcnt_d;
   logic signed [2:0]  fir_q,        fir_d;
   logic               en_acc_q,     en_acc_d;
   logic               err_q,        err_d;
   logic signed [15:0] coef_q [NTAP];
   logic signed [15:0] coef_d [NTAP];

   logic signed [2:0]  mem_q [FDEPTH];
   logic [c_AW-1:0]    wr_ptr_q,     wr_ptr_d;
   logic [c_AW-1:0]    rd_ptr_q,     rd_ptr_d;
   logic [c_AW:0]      cnt_q,        cnt_d;

   // -------------------------------------------------------------------------
   // Combinational helpers
   // -------------------------------------------------------------------------
   logic               w_full;
   logic               w_empty;
   logic               w_ready;
   logic               w_push;
   logic               w_pop;
   logic               w_coef_ok;
   logic signed [2:0]  w_head;
   logic signed [15:0] w_coef_pad [c_NOUT];

   assign w_full  = (cnt_q == c_FULL_CNT);
   assign w_empty = (cnt_q == '0);
   assign w_head  = mem_q[rd_ptr_q];

   // Ready depends only on registered state so upstream never sees a
   // combinational path from iStall or iFlush.
   assign w_ready = !w_full && (state_q != c_FLUSH);
   assign w_push  = iSampleValid && w_ready;
   assign w_pop   = (state_q == c_RUN) && !w_empty && !iStall;

   // The IDLE check uses the registered state, so a write landing on the
   // same edge as the IDLE->RUN transition is still accepted.
   assign w_coef_ok = iCoefWr && (state_q == c_IDLE) &&
                      ({1'b0, iCoefAddr} < c_NTAP);

   // -------------------------------------------------------------------------
   // Sample FIFO pointer / occupancy next-state
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_push, w_pop})
         2'b10:   cnt_d = cnt_q + c_CNT_ONE;
         2'b01:   cnt_d = cnt_q - c_CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // -------------------------------------------------------------------------
   // Control FSM and filter-side outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      fcnt_d       = fcnt_q;
      fir_d        = fir_q;
      en_acc_d     = 1'b1;

      case (state_q)
         c_IDLE: begin
            if (!w_empty) begin
               state_d = c_RUN;
            end
         end

         c_RUN: begin
            if (iFlush) begin
               flush_pend_d = 1'b1;
            end
            if (w_pop) begin
               fir_d    = w_head;
               en_acc_d = 1'b0;
            end else if (flush_pend_q && w_empty && !iStall) begin
               // The entry edge already emits the first zero sample, so the
               // count starts at one and FLUSH lasts exactly FLUSH_LEN cycles.
               state_d  = c_FLUSH;
               fir_d    = '0;
               en_acc_d = 1'b0;
               fcnt_d   = c_FCNT_ONE;
            end
         end

         c_FLUSH: begin
            if (!iStall) begin
               if (fcnt_q == c_FLUSH_LEN) begin
                  state_d      = c_IDLE;
                  fcnt_d       = '0;
                  flush_pend_d = 1'b0;
               end else begin
                  fir_d    = '0;
                  en_acc_d = 1'b0;
                  fcnt_d   = fcnt_q + c_FCNT_ONE;
               end
            end
         end

         default: begin
            state_d      = c_IDLE;
            flush_pend_d = 1'b0;
            fcnt_d       = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Coefficient bank next-state and sticky error
   // -------------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < NTAP; k++) begin
         coef_d[k] = coef_q[k];
         if (w_coef_ok && (iCoefAddr == 4'(k))) begin
            coef_d[k] = iCoefData;
         end
      end
      err_d = err_q | (iCoefWr & ~w_coef_ok);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge iClk_12M) begin
      if (iRst) begin
         state_q      <= c_IDLE;
         flush_pend_q <= 1'b0;
         fcnt_q       <= '0;
         fir_q        <= '0;
         en_acc_q     <= 1'b1;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         coef_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         fcnt_q       <= fcnt_d;
         fir_q        <= fir_d;
         en_acc_q     <= en_acc_d;
         err_q        <= err_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         coef_q       <= coef_d;
      end
   end

   // FIFO storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge iClk_12M) begin
      if (!iRst && w_push) begin
         mem_q[wr_ptr_q] <= iSample;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // Coefficient ports are fixed at ten; indices beyond NTAP read as zero.
   for (genvar k = 0; k < c_NOUT; k++) begin : g_coef_pad
      if (k < NTAP) begin : g_live
         assign w_coef_pad[k] = coef_q[k];
      end else begin : g_zero
         assign w_coef_pad[k] = '0;
      end
   end

   assign oCoeff1      = w_coef_pad[0];
   assign oCoeff2      = w_coef_pad[1];
   assign oCoeff3      = w_coef_pad[2];
   assign oCoeff4      = w_coef_pad[3];
   assign oCoeff5      = w_coef_pad[4];
   assign oCoeff6      = w_coef_pad[5];
   assign oCoeff7      = w_coef_pad[6];
   assign oCoeff8      = w_coef_pad[7];
   assign oCoeff9      = w_coef_pad[8];
   assign oCoeff10     = w_coef_pad[9];

   assign oSampleReady = w_ready;
   assign oFirIn       = fir_q;
   assign oEnAcc       = en_acc_q;
   assign oBusy        = (state_q != c_IDLE);
   assign oCoefErr     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_feeder
// Purpose  : Directed self-checking bench for fir_feeder: reset, coefficient
//            loading, streaming, backpressure, flush and reset during flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_feeder;

   logic               clk;
   logic               iRst;
   logic               iCoefWr;
   logic        [3:0]  iCoefAddr;
   logic signed [15:0] iCoefData;
   logic               iSampleValid;
   logic signed [2:0]  iSample;
   logic               oSampleReady;
   logic               iStall;
   logic               iFlush;
   logic signed [15:0] coef_o [10];
   logic signed [2:0]  oFirIn;
   logic               oEnAcc;
   logic               oBusy;
   logic               oCoefErr;

   int n_checks = 0;
   int n_errors = 0;

   fir_feeder #(
      .NTAP      (10),
      .FDEPTH    (4),
      .FLUSH_LEN (11)
   ) u_dut (
      .iClk_12M     (clk),
      .iRst         (iRst),
      .iCoefWr      (iCoefWr),
      .iCoefAddr    (iCoefAddr),
      .iCoefData    (iCoefData),
      .iSampleValid (iSampleValid),
      .iSample      (iSample),
      .oSampleReady (oSampleReady),
      .iStall       (iStall),
      .iFlush       (iFlush),
      .oCoeff1      (coef_o[0]),
      .oCoeff2      (coef_o[1]),
      .oCoeff3      (coef_o[2]),
      .oCoeff4      (coef_o[3]),
      .oCoeff5      (coef_o[4]),
      .oCoeff6      (coef_o[5]),
      .oCoeff7      (coef_o[6]),
      .oCoeff8      (coef_o[7]),
      .oCoeff9      (coef_o[8]),
      .oCoeff10     (coef_o[9]),
      .oFirIn       (oFirIn),
      .oEnAcc       (oEnAcc),
      .oBusy        (oBusy),
      .oCoefErr     (oCoefErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge; inputs are also
   // changed there so they are stable well before the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sx3(input logic signed [2:0] v);
      return {{29{v[2]}}, v};
   endfunction

   task automatic chk_reset_state(input string tag);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("%s_coef%0d", tag, k + 1), 32'(coef_o[k]), 32'd0);
      end
      chk({tag, "_fir"},   sx3(oFirIn),        32'd0);
      chk({tag, "_en"},    32'(oEnAcc),        32'd1);
      chk({tag, "_busy"},  32'(oBusy),         32'd0);
      chk({tag, "_err"},   32'(oCoefErr),      32'd0);
      chk({tag, "_ready"}, 32'(oSampleReady),  32'd1);
   endtask

   logic signed [2:0] bp_s [6];
   int                idx;

   initial begin
      iRst         = 1'b1;
      iCoefWr      = 1'b0;
      iCoefAddr    = '0;
      iCoefData    = '0;
      iSampleValid = 1'b0;
      iSample      = '0;
      iStall       = 1'b0;
      iFlush       = 1'b0;

      // ---------------- Reset held two cycles ----------------
      tick();
      tick();
      iRst = 1'b0;
      chk_reset_state("rst");

      // ---------------- Coefficient loading ----------------
      for (int a = 0; a < 10; a++) begin
         iCoefWr   = 1'b1;
         iCoefAddr = 4'(a);
         iCoefData = 16'(a + 1);
         tick();
      end
      iCoefWr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("load_coef%0d", k + 1), 32'(coef_o[k]), 32'(k + 1));
      end
      chk("load_err_clear", 32'(oCoefErr), 32'd0);

      iCoefWr   = 1'b1;
      iCoefAddr = 4'd12;
      iCoefData = 16'h7FFF;
      tick();
      iCoefWr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("badaddr_coef%0d", k + 1), 32'(coef_o[k]), 32'(k + 1));
      end
      chk("badaddr_err", 32'(oCoefErr), 32'd1);

      // ---------------- Streaming +1, -2, +3 ----------------
      // Push at edges A,B,C; IDLE->RUN at B; first pop at C.
      iStall       = 1'b0;
      iSampleValid = 1'b1;
      iSample      = 3'sd1;
      tick();
      iSample = -3'sd2;
      tick();
      iSample = 3'sd3;
      tick();
      iSampleValid = 1'b0;
      chk("stream0_fir", sx3(oFirIn), sx3(3'sd1));
      chk("stream0_en",  32'(oEnAcc), 32'd0);
      chk("stream_busy", 32'(oBusy),  32'd1);
      tick();
      chk("stream1_fir", sx3(oFirIn), sx3(-3'sd2));
      chk("stream1_en",  32'(oEnAcc), 32'd0);
      tick();
      chk("stream2_fir", sx3(oFirIn), sx3(3'sd3));
      chk("stream2_en",  32'(oEnAcc), 32'd0);
      tick();
      chk("stream_idle_en",  32'(oEnAcc), 32'd1);
      chk("stream_hold_fir", sx3(oFirIn), sx3(3'sd3));
      tick();
      chk("stream_hold2_en",  32'(oEnAcc), 32'd1);
      chk("stream_hold2_fir", sx3(oFirIn), sx3(3'sd3));

      // ---------------- Backpressure ----------------
      bp_s[0] = 3'sd1;  bp_s[1] = 3'sd2;  bp_s[2] = 3'sd3;
      bp_s[3] = -3'sd1; bp_s[4] = -3'sd2; bp_s[5] = -3'sd3;
      idx    = 0;
      iStall = 1'b1;
      // Upstream holds each sample until it is accepted.
      for (int c = 0; c < 6; c++) begin
         iSampleValid = 1'b1;
         iSample      = bp_s[idx];
         if (oSampleReady) idx++;
         tick();
      end
      chk("bp_accepted", 32'(idx),          32'd4);
      chk("bp_ready_lo", 32'(oSampleReady), 32'd0);
      chk("bp_stall_en", 32'(oEnAcc),       32'd1);
      chk("bp_hold_fir", sx3(oFirIn),       sx3(3'sd3));

      iStall = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (idx < 6) begin
            iSampleValid = 1'b1;
            iSample      = bp_s[idx];
         end else begin
            iSampleValid = 1'b0;
         end
         if (j == 0) chk("bp_ready_before_pop", 32'(oSampleReady), 32'd0);
         if (j == 1) chk("bp_ready_after_pop",  32'(oSampleReady), 32'd1);
         if (iSampleValid && oSampleReady) idx++;
         tick();
         chk($sformatf("bp_out%0d_fir", j), sx3(oFirIn), sx3(bp_s[j]));
         chk($sformatf("bp_out%0d_en", j),  32'(oEnAcc), 32'd0);
      end
      iSampleValid = 1'b0;
      chk("bp_all_accepted", 32'(idx), 32'd6);

      // ---------------- Flush ----------------
      iFlush = 1'b1;
      tick();
      iFlush = 1'b0;
      chk("flush_pulse_en",   32'(oEnAcc), 32'd1);
      chk("flush_pulse_busy", 32'(oBusy),  32'd1);
      tick();
      for (int f = 1; f <= 11; f++) begin
         chk($sformatf("flush%0d_fir", f),   sx3(oFirIn),        32'd0);
         chk($sformatf("flush%0d_en", f),    32'(oEnAcc),        32'd0);
         chk($sformatf("flush%0d_busy", f),  32'(oBusy),         32'd1);
         chk($sformatf("flush%0d_ready", f), 32'(oSampleReady),  32'd0);
         // Coefficient write and a repeated flush pulse during the flush.
         iCoefWr   = (f == 3);
         iCoefAddr = 4'd0;
         iCoefData = 16'sh1234;
         iFlush    = (f == 6);
         tick();
      end
      iCoefWr = 1'b0;
      iFlush  = 1'b0;
      chk("flush_done_busy", 32'(oBusy),     32'd0);
      chk("flush_done_en",   32'(oEnAcc),    32'd1);
      chk("flush_done_fir",  sx3(oFirIn),    32'd0);
      chk("flush_wr_coef1",  32'(coef_o[0]), 32'd1);
      chk("flush_wr_err",    32'(oCoefErr),  32'd1);

      // iFlush in IDLE is ignored.
      iFlush = 1'b1;
      tick();
      iFlush = 1'b0;
      tick();
      chk("idle_flush_busy", 32'(oBusy),  32'd0);
      chk("idle_flush_en",   32'(oEnAcc), 32'd1);

      // ---------------- Reset during FLUSH ----------------
      iRst = 1'b1;
      tick();
      iRst = 1'b0;
      chk("rst2_err",   32'(oCoefErr),  32'd0);
      chk("rst2_coef1", 32'(coef_o[0]), 32'd0);

      iSampleValid = 1'b1;
      iSample      = 3'sd2;
      tick();                     // push
      iSampleValid = 1'b0;
      tick();                     // IDLE -> RUN
      iFlush = 1'b1;
      tick();                     // pop +2, flush latched
      iFlush = 1'b0;
      chk("mid_pop_fir", sx3(oFirIn), sx3(3'sd2));
      tick();                     // RUN -> FLUSH, cycle 1
      chk("mid_f1_busy", 32'(oBusy),  32'd1);
      chk("mid_f1_en",   32'(oEnAcc), 32'd0);
      tick();                     // cycle 2
      iCoefWr   = 1'b1;
      iCoefAddr = 4'd1;
      iCoefData = 16'sd5;
      tick();                     // cycle 3, write rejected
      iCoefWr = 1'b0;
      chk("mid_wr_err",   32'(oCoefErr),  32'd1);
      chk("mid_wr_coef2", 32'(coef_o[1]), 32'd0);
      tick();                     // cycle 4
      tick();                     // cycle 5
      chk("mid_f5_en",   32'(oEnAcc), 32'd0);
      chk("mid_f5_busy", 32'(oBusy),  32'd1);
      iRst = 1'b1;
      tick();
      iRst = 1'b0;
      chk_reset_state("rst3");
      tick();
      chk("rst3_fifo_empty_busy", 32'(oBusy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fir_feeder.md
FIR_FEEDER -- requirements
Module: fir_feeder

Parameters
REQ-001 The block SHALL have parameter NTAP, default 10, meaning the number of coefficient registers driven to the filter.
REQ-002 The block SHALL have parameter FDEPTH, default 4, meaning the number of sample FIFO entries (power of two).
REQ-003 The block SHALL have parameter FLUSH_LEN, default 11, meaning the number of zero samples injected per flush (NTAP plus 1 output register).

Interface
REQ-004 The block SHALL have port iClk_12M, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port iRst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port iCoefWr, input, 1 bit: coefficient write strobe.
REQ-007 The block SHALL have port iCoefAddr, input, 4 bits: coefficient index 0..NTAP-1.
REQ-008 The block SHALL have port iCoefData, input, 16 bits signed: coefficient value.
REQ-009 The block SHALL have port iSampleValid, input, 1 bit: upstream sample valid.
REQ-010 The block SHALL have port iSample, input, 3 bits signed: sample value.
REQ-011 The block SHALL have port oSampleReady, output, 1 bit: sample accepted on an edge where iSampleValid and oSampleReady are both 1.
REQ-012 The block SHALL have port iStall, input, 1 bit: downstream pause request.
REQ-013 The block SHALL have port iFlush, input, 1 bit: single-cycle flush request.
REQ-014 The block SHALL have ports oCoeff1..oCoeff10, output, 16 bits signed each: coefficient registers, index k drives oCoeff(k+1).
REQ-015 The block SHALL have port oFirIn, output, 3 bits signed: sample to the filter.
REQ-016 The block SHALL have port oEnAcc, output, 1 bit: active-low filter advance enable.
REQ-017 The block SHALL have port oBusy, output, 1 bit: 1 when the state is not IDLE.
REQ-018 The block SHALL have port oCoefErr, output, 1 bit: sticky illegal-write flag.

Function
REQ-019 The block SHALL implement states IDLE, RUN and FLUSH, each held in a register.
REQ-020 In IDLE, a write with iCoefAddr < NTAP SHALL update the addressed oCoeff on the next edge.
REQ-021 A write with iCoefAddr >= NTAP, or any write in RUN or FLUSH, SHALL leave all coefficients unchanged and set oCoefErr, which stays set until reset.
REQ-022 oSampleReady SHALL be 1 only when the FIFO is not full and the state is not FLUSH, and it SHALL be a combinational function of registered state only.
REQ-023 A push and a pop on the same edge SHALL both take effect, leaving the occupancy unchanged.
REQ-024 IDLE SHALL go to RUN on the edge after the FIFO becomes non-empty; a coefficient write on that same edge SHALL still be accepted.
REQ-025 In RUN, when the FIFO is non-empty and iStall is 0, the block SHALL pop one entry per edge, register it onto oFirIn, and drive oEnAcc to 0.
REQ-026 In RUN, when the FIFO is empty or iStall is 1, the block SHALL drive oEnAcc to 1 and hold oFirIn.
REQ-027 An iFlush pulse in RUN SHALL be latched; any further iFlush pulses SHALL have no effect until the flush completes.
REQ-028 RUN SHALL go to FLUSH when a flush request is pending, the FIFO is empty, and iStall is 0.
REQ-029 iFlush in IDLE SHALL be ignored.
REQ-030 FLUSH SHALL drive oFirIn to 0 and oEnAcc to 0 for exactly FLUSH_LEN cycles, then return to IDLE with the flush request cleared.
REQ-031 iStall in FLUSH SHALL pause the FLUSH_LEN count and drive oEnAcc to 1.
REQ-032 The latency from a sample being accepted to it appearing on oFirIn SHALL be 2 edges minimum when the FIFO is empty and not stalled (1 edge to enqueue, 1 edge to pop and register).
REQ-033 Full FIFO with valid asserted: the sample SHALL be held upstream and not dropped; oSampleReady SHALL rise in the cycle after a pop.

Reset
REQ-034 When iRst is 1 at an edge, the block SHALL go to IDLE, empty the FIFO, and clear the flush request and the FLUSH counter.
REQ-035 Reset SHALL set all oCoeff to 0, oFirIn to 0, oEnAcc to 1, oBusy to 0 and oCoefErr to 0.
REQ-036 Reset SHALL take priority over all other inputs, including a reset arriving in RUN or FLUSH.
REQ-037 oSampleReady SHALL be 1 in the cycle after reset.

Verification
REQ-038 The bench SHALL cover reset: hold iRst 2 cycles -> all oCoeff 0, oFirIn 0, oEnAcc 1, oBusy 0, oCoefErr 0, oSampleReady 1.
REQ-039 The bench SHALL cover coefficient loading: in IDLE write addr 0..9 with data 1..10 -> oCoeff1..oCoeff10 = 1..10; then write addr 12 with data 0x7FFF -> coefficients unchanged and oCoefErr = 1.
REQ-040 The bench SHALL cover streaming: push +1, -2, +3 on consecutive cycles with iStall 0 -> oFirIn = +1, -2, +3 on 3 consecutive cycles with oEnAcc 0, then oEnAcc 1 and oFirIn held at +3.
REQ-041 The bench SHALL cover backpressure: with iStall 1 in RUN, offer 6 samples -> exactly 4 accepted and oSampleReady 0; release iStall -> the 4 samples appear in order and the 5th is accepted the cycle after the first pop.
REQ-042 The bench SHALL cover flush: after the last sample, pulse iFlush -> 11 cycles of oFirIn 0 with oEnAcc 0, then IDLE with oBusy 0; a coefficient write during the flush sets oCoefErr.
REQ-043 The bench SHALL cover reset mid-operation: assert iRst during FLUSH cycle 5 -> IDLE next edge, FIFO empty, coefficients 0, oEnAcc 1.
